// File: rtl/runway_pkg.sv
// Shared definitions for the runway scheduler: aircraft class encodings,
// runway identifiers and the class-to-preferred-runway mapping.
package runway_pkg;

    typedef enum logic [1:0] {
        AC_T00 = 2'b00,
        AC_T01 = 2'b01,
        AC_T10 = 2'b10,
        AC_T11 = 2'b11
    } ac_type_e;

    localparam logic RWY_A = 1'b0;
    localparam logic RWY_B = 1'b1;

    localparam int unsigned OCC_CYCLES_DEF = 15;

    typedef struct packed {
        ac_type_e   ac_type;
        logic [3:0] id;
    } req_entry_t;

    function automatic logic pref_runway(input ac_type_e t);
        logic r;
        case (t)
            AC_T01, AC_T11: r = RWY_A;
            default:        r = RWY_B;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/runway_timer.sv
// Occupancy timer for one runway: loads OCC_CYCLES on a grant, counts down
// every cycle, and reports busy while non-zero.
module runway_timer #(
    parameter int unsigned OCC_CYCLES = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic busy_o
);

    localparam int unsigned CW = $clog2(OCC_CYCLES + 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = CW'(OCC_CYCLES);
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign busy_o = (count_q != '0);

endmodule

// File: rtl/runway_scheduler.sv
// Two-runway scheduler: a FIFO of aircraft requests whose head is granted
// to its preferred runway, or the alternate one, when free and not on hold.
module runway_scheduler
    import runway_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned OCC_CYCLES = OCC_CYCLES_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_type,
    input  logic [3:0]               req_id,
    input  logic                     hold,
    output logic                     grant_valid,
    output logic [3:0]               grant_id,
    output logic                     grant_runway,
    output logic                     busy_a,
    output logic                     busy_b,
    output logic [$clog2(DEPTH):0]   queue_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    req_entry_t       mem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             gvalid_q, gvalid_d;
    logic [3:0]       gid_q, gid_d;
    logic             grwy_q, grwy_d;

    req_entry_t       head_entry;
    logic             pref, pref_free, alt_free, sel_rwy;
    logic             push, pop;
    logic             load_a, load_b;

    // Ready looks only at the registered count, so a full queue refuses a
    // push even on a cycle where the head is being granted.
    assign req_ready = (count_q < CW'(DEPTH));
    assign push      = req_valid && req_ready;

    always_comb begin
        head_entry = mem_q[head_q];
        pref       = pref_runway(head_entry.ac_type);
        pref_free  = (pref == RWY_A) ? !busy_a : !busy_b;
        alt_free   = (pref == RWY_A) ? !busy_b : !busy_a;
        pop        = (count_q != '0) && !hold && (pref_free || alt_free);
        sel_rwy    = pref_free ? pref : !pref;
        load_a     = pop && (sel_rwy == RWY_A);
        load_b     = pop && (sel_rwy == RWY_B);
    end

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        gvalid_d = pop;
        gid_d    = gid_q;
        grwy_d   = grwy_q;
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
            gid_d  = head_entry.id;
            grwy_d = sel_rwy;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            gvalid_q <= 1'b0;
            gid_q    <= '0;
            grwy_q   <= RWY_A;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            gvalid_q <= gvalid_d;
            gid_q    <= gid_d;
            grwy_q   <= grwy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= '{ac_type: ac_type_e'(req_type), id: req_id};
        end
    end

    runway_timer #(.OCC_CYCLES(OCC_CYCLES)) u_timer_a (
        .clk    (clk),
        .rst    (rst),
        .load_i (load_a),
        .busy_o (busy_a)
    );

    runway_timer #(.OCC_CYCLES(OCC_CYCLES)) u_timer_b (
        .clk    (clk),
        .rst    (rst),
        .load_i (load_b),
        .busy_o (busy_b)
    );

    assign grant_valid  = gvalid_q;
    assign grant_id     = gid_q;
    assign grant_runway = grwy_q;
    assign queue_count  = count_q;

endmodule

// File: tb/tb_runway_scheduler.sv
// Directed bench for runway_scheduler with DEPTH=4, OCC_CYCLES=15.
module tb_runway_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_type;
    logic [3:0] req_id;
    logic       hold;
    logic       grant_valid;
    logic [3:0] grant_id;
    logic       grant_runway;
    logic       busy_a;
    logic       busy_b;
    logic [2:0] queue_count;

    int n_cmp = 0;
    int n_err = 0;

    runway_scheduler #(.DEPTH(4), .OCC_CYCLES(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_type     (req_type),
        .req_id       (req_id),
        .hold         (hold),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .grant_runway (grant_runway),
        .busy_a       (busy_a),
        .busy_b       (busy_b),
        .queue_count  (queue_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (!busy_a && !busy_b) break;
            tick();
        end
        chk({tag, "_idle"}, 32'({busy_a, busy_b}), 32'd0);
    endtask

    task automatic get_grant(input string tag, input int exp_id, input int exp_rwy);
        for (int i = 0; i < 60; i++) begin
            tick();
            if (grant_valid) break;
        end
        chk({tag, "_gv"}, 32'(grant_valid), 32'd1);
        chk({tag, "_id"}, 32'(grant_id), 32'(exp_id));
        chk({tag, "_rwy"}, 32'(grant_runway), 32'(exp_rwy));
    endtask

    task automatic push1(input int t, input int id);
        req_valid = 1'b1;
        req_type  = 2'(t);
        req_id    = 4'(id);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        int grants;
        int sent;
        int rx;
        logic acc;

        rst = 1'b1; req_valid = 1'b0; req_type = '0; req_id = '0; hold = 1'b0;
        tick(); tick();
        chk("rst_count", 32'(queue_count), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_gv", 32'(grant_valid), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_grwy", 32'(grant_runway), 32'd0);
        chk("rst_busy", 32'({busy_a, busy_b}), 32'd0);
        rst = 1'b0;
        tick();

        // Single request, type 01 id 3 -> runway A, busy 15 cycles
        push1(1, 3);
        req_valid = 1'b0;
        chk("t1_count", 32'(queue_count), 32'd1);
        chk("t1_nogv", 32'(grant_valid), 32'd0);
        tick();
        chk("t1_gv", 32'(grant_valid), 32'd1);
        chk("t1_id", 32'(grant_id), 32'd3);
        chk("t1_rwy", 32'(grant_runway), 32'd0);
        chk("t1_busy", 32'({busy_a, busy_b}), 32'b10);
        chk("t1_count0", 32'(queue_count), 32'd0);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 0) chk("t1_pulse", 32'(grant_valid), 32'd0);
            if (!busy_a) break;
            n++;
        end
        chk("t1_busy_len", 32'(n), 32'd15);

        // Three type-00 requests: B, then A, then B again once it frees
        push1(0, 1);
        push1(0, 2);
        chk("t2_id1", 32'(grant_id), 32'd1);
        chk("t2_rwy1", 32'(grant_runway), 32'd1);
        push1(0, 4);
        req_valid = 1'b0;
        chk("t2_id2", 32'(grant_id), 32'd2);
        chk("t2_rwy2", 32'(grant_runway), 32'd0);
        chk("t2_count", 32'(queue_count), 32'd1);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            k++;
            if (grant_valid) break;
        end
        chk("t2_wait", 32'(k), 32'd15);
        chk("t2_id4", 32'(grant_id), 32'd4);
        chk("t2_rwy4", 32'(grant_runway), 32'd1);
        wait_idle("t2");

        // Occupy both runways, then fill the queue; 5th request refused
        push1(1, 5);
        push1(0, 6);
        chk("t3_id5", 32'(grant_id), 32'd5);
        push1(1, 7);
        chk("t3_id6", 32'(grant_id), 32'd6);
        chk("t3_rwy6", 32'(grant_runway), 32'd1);
        push1(0, 8);
        push1(3, 9);
        push1(2, 10);
        chk("t3_full", 32'(queue_count), 32'd4);
        chk("t3_ready", 32'(req_ready), 32'd0);
        push1(1, 11);
        req_valid = 1'b0;
        chk("t3_full2", 32'(queue_count), 32'd4);
        get_grant("t3_g7", 7, 0);
        get_grant("t3_g8", 8, 1);
        get_grant("t3_g9", 9, 0);
        get_grant("t3_g10", 10, 1);
        chk("t3_empty", 32'(queue_count), 32'd0);
        wait_idle("t3");

        // Hold for 20 cycles with two queued requests
        push1(1, 1);
        req_valid = 1'b0;
        tick();
        chk("t4_id1", 32'(grant_id), 32'd1);
        hold = 1'b1;
        grants = 0;
        push1(1, 12);
        if (grant_valid) grants++;
        push1(0, 13);
        if (grant_valid) grants++;
        req_valid = 1'b0;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (grant_valid) grants++;
        end
        chk("t4_nogrant", 32'(grants), 32'd0);
        chk("t4_expired", 32'({busy_a, busy_b}), 32'd0);
        chk("t4_count", 32'(queue_count), 32'd2);
        hold = 1'b0;
        tick();
        chk("t4_gv12", 32'(grant_valid), 32'd1);
        chk("t4_id12", 32'(grant_id), 32'd12);
        chk("t4_rwy12", 32'(grant_runway), 32'd0);
        tick();
        chk("t4_id13", 32'(grant_id), 32'd13);
        chk("t4_rwy13", 32'(grant_runway), 32'd1);
        wait_idle("t4");

        // Asynchronous reset with A busy and three entries queued
        push1(1, 1);
        req_valid = 1'b0;
        tick();
        hold = 1'b1;
        push1(0, 2);
        push1(0, 3);
        push1(0, 4);
        req_valid = 1'b0;
        chk("t5_pre_count", 32'(queue_count), 32'd3);
        chk("t5_pre_busy", 32'(busy_a), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("t5_count", 32'(queue_count), 32'd0);
        chk("t5_ready", 32'(req_ready), 32'd1);
        chk("t5_gid", 32'(grant_id), 32'd0);
        chk("t5_gv", 32'(grant_valid), 32'd0);
        chk("t5_busy", 32'({busy_a, busy_b}), 32'd0);
        #1 rst = 1'b0;
        hold = 1'b0;
        push1(2, 9);
        req_valid = 1'b0;
        chk("t5_post_gv0", 32'(grant_valid), 32'd0);
        tick();
        chk("t5_post_gv", 32'(grant_valid), 32'd1);
        chk("t5_post_id", 32'(grant_id), 32'd9);
        chk("t5_post_rwy", 32'(grant_runway), 32'd1);
        wait_idle("t5");

        // Sustained traffic of 12 requests through a 4-deep queue
        sent = 0;
        rx = 0;
        for (int i = 0; i < 600; i++) begin
            req_valid = (sent < 12);
            req_type  = 2'(sent);
            req_id    = 4'(sent);
            acc       = req_valid && req_ready;
            tick();
            if (acc) sent++;
            if (grant_valid) begin
                chk("t6_order", 32'(grant_id), 32'(rx));
                rx++;
            end
            if (rx == 12) break;
        end
        req_valid = 1'b0;
        chk("t6_rx", 32'(rx), 32'd12);
        chk("t6_empty", 32'(queue_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/runway_scheduler.md
RUNWAY_SCHEDULER -- requirements
Module: runway_scheduler

Interface
REQ-001 Parameter: DEPTH, 4, request queue entries (power of two, >=2).
REQ-002 Parameter: OCC_CYCLES, 15, clock cycles a runway stays occupied after a grant (>=1).
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: req_valid  input  1  aircraft request present.
REQ-006 Port: req_ready  output  1  queue can accept a request this cycle.
REQ-007 Port: req_type  input  2  aircraft class: 00, 01, 10, 11.
REQ-008 Port: req_id  input  4  aircraft tag, returned with its grant.
REQ-009 Port: hold  input  1  tower hold; suppresses new grants.
REQ-010 Port: grant_valid  output  1  one-cycle pulse, a grant is issued.
REQ-011 Port: grant_id  output  4  tag of the granted aircraft.
REQ-012 Port: grant_runway  output  1  0 = runway A, 1 = runway B.
REQ-013 Port: busy_a, busy_b  output  1 each  runway occupied.
REQ-014 Port: queue_count  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-015 Request accepted when req_valid && req_ready; {req_type, req_id} written at the queue tail.
REQ-016 req_ready = (queue_count < DEPTH); depends only on registered count, so no push when full, even in a cycle with a pop.
REQ-017 Queue is strict FIFO; only the head entry is eligible for a grant.
REQ-018 Preferred runway: types 00 and 10 prefer B; types 01 and 11 prefer A.
REQ-019 Each cycle with queue non-empty, hold low and preferred runway free: grant preferred runway.
REQ-020 Preferred runway busy, alternate free, hold low: grant alternate runway.
REQ-021 Both runways busy or hold high: no grant; head entry retained unchanged.
REQ-022 At most one grant per cycle; grant pops the head entry in the same edge.
REQ-023 grant_valid, grant_id, grant_runway are registered; they assert the cycle after the edge on which the decision is made; grant_id/grant_runway hold last values when grant_valid is low.
REQ-024 Latency: request accepted at edge N into empty queue with a free runway -> grant_valid high after edge N+1.
REQ-025 On grant, that runway's timer loads OCC_CYCLES; busy_x high for exactly OCC_CYCLES cycles starting with the grant_valid cycle.
REQ-026 Timer decrements every cycle regardless of hold; runway is free when timer is 0 and may be re-granted on the edge where busy_x falls.
REQ-027 Simultaneous push and pop: queue_count unchanged, new entry at tail, head advances.
REQ-028 Push into empty queue is not eligible for grant on its own write edge.
REQ-029 Pointer wrap-around modulo DEPTH is transparent to ordering.

Reset
REQ-030 rst high: queue emptied, queue_count = 0, req_ready = 1 after release, grant_valid = 0, grant_id = 0, grant_runway = 0, both timers = 0, busy_a = busy_b = 0.
REQ-031 Reset asserted mid-operation discards queued requests and in-progress occupancy immediately, without waiting for a clock edge.

Structure
REQ-032 Shared package runway_pkg holds: type encodings (00-11), runway constants RWY_A = 0 / RWY_B = 1, default OCC_CYCLES = 15, preference function type -> runway.
REQ-033 Sub-module runway_timer (load, count, busy output), instantiated once per runway.
REQ-034 Queue storage and arbitration reside in runway_scheduler itself.

Verification
REQ-035 Reset, then single request type 01 id 3 -> grant_valid one cycle later, grant_id = 3, grant_runway = A, busy_a high 15 cycles.
REQ-036 Two back-to-back type 00 requests ids 1, 2 -> id 1 on B, id 2 on A next cycle; third type 00 id 4 waits until B frees, granted on B.
REQ-037 Fill queue with 4 requests while both runways busy -> req_ready low, 5th request not accepted, queue_count = 4; FIFO order of grants preserved after release.
REQ-038 hold high for 20 cycles with 2 queued requests -> no grant_valid; timers still expire; grants resume the cycle after hold drops.
REQ-039 Assert rst while busy_a high and queue_count = 3 -> all outputs at reset values immediately; post-reset request granted with normal latency.
REQ-040 Continuous push/pop traffic for 3*DEPTH requests -> pointer wrap-around, no lost or duplicated grant_id.
